fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
Sequencer and access arbiter for the 32x16 FFT sample buffer and its accelerator. The CPU reaches the block through one memory window. The block passes sample writes into the buffer and tracks which words are filled. It starts the accelerator and waits for completion, then pulses the buffer's accelerator-capture enable. While a job is in flight it stalls CPU sample writes, and it raises an interrupt on completion or error.

Parameters:
NPOINTS, 32, number of sample words in the buffer.
ADDR_W, 6, CPU/buffer address width.
TIMEOUT_CYCLES, 1024, RUN-state watchdog limit (used only with FFT_CTRL_TIMEOUT_EN).

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-low
cpu_en_i  input  1  CPU access request
cpu_we_i  input  1  1 = write, 0 = read
cpu_addr_i  input  ADDR_W  word address
cpu_data_i  input  32  write data
cpu_gnt_o  output  1  combinational grant; an access completes in any cycle with cpu_en_i & cpu_gnt_o
cpu_rdata_o  output  32  registered read data, valid the cycle after a granted read
buf_en_o  output  1  buffer enable
buf_we_o  output  1  buffer write enable
buf_addr_o  output  ADDR_W  buffer address
buf_data_o  output  32  buffer write data
accel_mem_en_o  output  1  one-cycle buffer capture enable for accelerator results
accel_start_o  output  1  one-cycle accelerator start pulse
accel_done_i  input  1  accelerator completion pulse/level
irq_o  output  1  registered interrupt

Behaviour:
- Address map:
  - 0..NPOINTS-1: sample window.
  - 0x20 CTRL (write-only). Bits: bit0 START, bit1 AUTO (sticky config), bit2 IRQ_CLR, bit3 ABORT.
  - 0x21 STATUS (read-only). Bits: [1:0] state, [2] AUTO, [4] full, [5] done, [6] err_incomplete, [7] err_timeout, [13:8] fill count.
  - Any other address: always granted; writes ignored, reads return 0. CTRL reads 0. Writes to STATUS are ignored.
- State encoding: IDLE=0, START=1, RUN=2, CAPTURE=3.
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - fill bitmap, fill count, AUTO, done, err_incomplete, err_timeout all go to 0.
  - All outputs are 0, except cpu_gnt_o, which follows the grant rule.
- Grant rules:
  - In IDLE, every access is granted.
  - In START, RUN and CAPTURE, sample-window accesses get cpu_gnt_o=0 and are held off until the block returns to IDLE.
  - CTRL and STATUS accesses are always granted.
- Buffer path (combinational):
  - buf_en_o = cpu_en_i & cpu_gnt_o & (addr < NPOINTS).
  - buf_we_o = buf_en_o & cpu_we_i.
  - buf_addr_o and buf_data_o are passthroughs of cpu_addr_i and cpu_data_i.
  - Sample-window reads return 0 on cpu_rdata_o; the buffer has no read port.
- Fill tracking:
  - Each granted sample write sets its bitmap bit.
  - fill count increments only on the first write to a word; rewriting a word leaves it unchanged.
  - full = (count == NPOINTS).
  - Bitmap and count clear on leaving CAPTURE, on ABORT, and on timeout.
- IDLE:
  - START with full=1 goes to START.
  - START with full=0 stays in IDLE and sets err_incomplete.
  - With AUTO=1, the granted write that makes full=1 goes to START on the next edge, with no CPU command.
- START: accel_start_o=1 for exactly one cycle, then RUN.
- RUN: accel_done_i=1 goes to CAPTURE.
- CAPTURE: accel_mem_en_o=1 for exactly one cycle. On exit, go to IDLE and set done.
- ABORT:
  - Takes effect from any state: go to IDLE, clear fill.
  - Does not set done. accel_mem_en_o is not asserted.
  - If START and ABORT are written together, ABORT wins.
- accel_done_i outside RUN is ignored.
- Interrupt:
  - irq_o is registered: irq_o = done | err_timeout.
  - IRQ_CLR clears done, err_incomplete and err_timeout.
  - If IRQ_CLR coincides with a flag being set in the same cycle, the set wins.
- Latency from completing the last sample write (AUTO=1):
  - accel_start_o high 1 cycle later.
  - After accel_done_i, accel_mem_en_o high the next cycle.
  - done/irq_o high the cycle after that.

Optional Feature:
FFT_CTRL_TIMEOUT_EN:
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without accel_done_i, go to IDLE, clear fill and set err_timeout. irq_o asserts the next cycle.
  - If accel_done_i arrives in the same cycle as expiry, done wins.
- Undefined: no counter; RUN waits indefinitely; STATUS[7] reads 0.

Test Plan:
- Reset, then read STATUS -> 0x0000. Write words 0..31 with data=index, AUTO=0, then read STATUS -> state=0, full=1, count=32. Check buf_we_o pulsed 32 times with matching addr/data.
- Write words 0..30, then write word 5 again, then CTRL=0x1 -> count=31, no accel_start_o, err_incomplete=1, irq_o=0.
- Fill 32 words, then CTRL=0x1; accel_done_i after 10 RUN cycles. Expect:
  - accel_start_o for 1 cycle.
  - A sample write during RUN sees cpu_gnt_o=0 until IDLE.
  - accel_mem_en_o for 1 cycle.
  - irq_o=1, then count=0. CTRL=0x4 -> irq_o=0.
- CTRL=0x2 (AUTO), then write 32 words -> accel_start_o one cycle after the 32nd grant, with no CTRL START.
- In RUN, CTRL=0x8 (ABORT) -> IDLE, count=0, done=0. A later accel_done_i produces no accel_mem_en_o.
- With FFT_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, start a job and never assert done -> after 16 RUN cycles: IDLE, err_timeout=1, irq_o=1.

Source files
------------

// File: rtl/fft_seq_ctrl_if.sv
// CPU memory-window bus for the FFT sequencer: request, grant and read data.
// The CPU side drives the request; the sequencer answers with grant and read data.
interface fft_seq_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              cpu_en_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic              cpu_gnt_o;
    logic [31:0]       cpu_rdata_o;

    modport master (
        output cpu_en_i,
        output cpu_we_i,
        output cpu_addr_i,
        output cpu_data_i,
        input  cpu_gnt_o,
        input  cpu_rdata_o
    );

    modport slave (
        input  cpu_en_i,
        input  cpu_we_i,
        input  cpu_addr_i,
        input  cpu_data_i,
        output cpu_gnt_o,
        output cpu_rdata_o
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// FFT sample-buffer arbiter and job sequencer (fill tracking, start, capture, irq).
// Define FFT_CTRL_TIMEOUT_EN to add the RUN-state watchdog.
module fft_seq_ctrl #(
    parameter int NPOINTS        = 32,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    fft_seq_ctrl_if.slave     cpu,
    output logic              buf_en_o,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [31:0]       buf_data_o,
    output logic              accel_mem_en_o,
    output logic              accel_start_o,
    input  logic              accel_done_i,
    output logic              irq_o
);
    localparam int IDX_W = $clog2(NPOINTS);
    localparam int CNT_W = $clog2(NPOINTS + 1);

    localparam logic [ADDR_W-1:0] NPTS_A = ADDR_W'(NPOINTS);
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(32);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(33);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NPOINTS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NPOINTS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_n;
    logic [NPOINTS-1:0] fill;
    logic [CNT_W-1:0]   count;
    logic               auto_en;
    logic               done;
    logic               err_inc;
    logic               err_to;

    logic [IDX_W-1:0]   slot;
    logic               in_win;
    logic               gnt;
    logic               acc;
    logic               smp_wr;
    logic               ctrl_wr;
    logic               stat_rd;
    logic               start_cmd;
    logic               abort_cmd;
    logic               clr_cmd;
    logic               first_wr;
    logic               full;
    logic               expire;
    logic               fill_clr;
    logic               set_done;
    logic               set_inc;
    logic               set_to;
    logic               done_n;
    logic               err_inc_n;
    logic               err_to_n;
    logic [31:0]        status;

    always_comb begin
        slot      = cpu.cpu_addr_i[IDX_W-1:0];
        in_win    = cpu.cpu_addr_i < NPTS_A;
        gnt       = (state == S_IDLE) | ~in_win;
        acc       = cpu.cpu_en_i & gnt;
        smp_wr    = acc & cpu.cpu_we_i & in_win;
        ctrl_wr   = acc & cpu.cpu_we_i & (cpu.cpu_addr_i == CTRL_A);
        stat_rd   = cpu.cpu_addr_i == STAT_A;
        start_cmd = ctrl_wr & cpu.cpu_data_i[0];
        clr_cmd   = ctrl_wr & cpu.cpu_data_i[2];
        abort_cmd = ctrl_wr & cpu.cpu_data_i[3];
        first_wr  = smp_wr & ~fill[slot];
        full      = count == CNT_FULL;
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Counter is held at zero outside RUN, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != S_RUN) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign expire = (state == S_RUN) & (to_cnt == TO_LAST);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        fill_clr = 1'b0;
        set_done = 1'b0;
        set_inc  = 1'b0;
        set_to   = 1'b0;
        if (abort_cmd) begin
            state_n  = S_IDLE;
            fill_clr = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_cmd) begin
                        if (full) state_n = S_START;
                        else      set_inc = 1'b1;
                    end else if (auto_en & first_wr & (count == CNT_LAST)) begin
                        state_n = S_START;
                    end
                end
                S_START: state_n = S_RUN;
                S_RUN: begin
                    if (accel_done_i) begin
                        state_n = S_CAPTURE;
                    end else if (expire) begin
                        state_n  = S_IDLE;
                        fill_clr = 1'b1;
                        set_to   = 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state_n  = S_IDLE;
                    fill_clr = 1'b1;
                    set_done = 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // A flag being set in the same cycle as IRQ_CLR survives the clear.
    always_comb begin
        done_n    = set_done | (done & ~clr_cmd);
        err_inc_n = set_inc | (err_inc & ~clr_cmd);
        err_to_n  = set_to | (err_to & ~clr_cmd);
    end

    always_comb begin
        status              = 32'd0;
        status[1:0]         = state;
        status[2]           = auto_en;
        status[4]           = full;
        status[5]           = done;
        status[6]           = err_inc;
        status[7]           = err_to;
        status[8 +: CNT_W]  = count;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            fill            <= '0;
            count           <= '0;
            auto_en         <= 1'b0;
            done            <= 1'b0;
            err_inc         <= 1'b0;
            err_to          <= 1'b0;
            irq_o           <= 1'b0;
            cpu.cpu_rdata_o <= 32'd0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            err_inc <= err_inc_n;
            err_to  <= err_to_n;
            irq_o   <= done_n | err_to_n;
            if (fill_clr) begin
                fill  <= '0;
                count <= '0;
            end else if (first_wr) begin
                fill[slot] <= 1'b1;
                count      <= count + CNT_W'(1);
            end
            if (ctrl_wr) begin
                auto_en <= cpu.cpu_data_i[1];
            end
            if (acc & ~cpu.cpu_we_i) begin
                cpu.cpu_rdata_o <= stat_rd ? status : 32'd0;
            end
        end
    end

    assign cpu.cpu_gnt_o  = gnt;
    assign buf_en_o       = cpu.cpu_en_i & gnt & in_win;
    assign buf_we_o       = buf_en_o & cpu.cpu_we_i;
    assign buf_addr_o     = cpu.cpu_addr_i;
    assign buf_data_o     = cpu.cpu_data_i;
    assign accel_start_o  = state == S_START;
    assign accel_mem_en_o = (state == S_CAPTURE) & ~abort_cmd;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: fill, start, run, capture, abort, auto, irq.
// Build with FFT_CTRL_TIMEOUT_EN to exercise the watchdog path.
module tb_fft_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        buf_en;
    logic        buf_we;
    logic [5:0]  buf_addr;
    logic [31:0] buf_data;
    logic        accel_mem_en;
    logic        accel_start;
    logic        accel_done;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int we_bad = 0;
    int start_cnt = 0;
    int memen_cnt = 0;
    int snap;
    logic [31:0] rv;

    fft_seq_ctrl_if #(.ADDR_W(6)) cpu_bus ();

    fft_seq_ctrl #(
        .NPOINTS(32),
        .ADDR_W(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu(cpu_bus),
        .buf_en_o(buf_en),
        .buf_we_o(buf_we),
        .buf_addr_o(buf_addr),
        .buf_data_o(buf_data),
        .accel_mem_en_o(accel_mem_en),
        .accel_start_o(accel_start),
        .accel_done_i(accel_done),
        .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (buf_we) begin
            we_cnt++;
            if (buf_data !== {26'd0, buf_addr}) we_bad++;
        end
        if (accel_start) start_cnt++;
        if (accel_mem_en) memen_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        @(negedge clk);
        while (!cpu_bus.cpu_gnt_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_bus.cpu_gnt_o) check("gnt_wait", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cpu_bus.cpu_en_i   = 1'b1;
        cpu_bus.cpu_we_i   = 1'b1;
        cpu_bus.cpu_addr_i = a;
        cpu_bus.cpu_data_i = d;
        wait_gnt();
        @(posedge clk);
        #1;
        cpu_bus.cpu_en_i = 1'b0;
        cpu_bus.cpu_we_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        cpu_bus.cpu_en_i   = 1'b1;
        cpu_bus.cpu_we_i   = 1'b0;
        cpu_bus.cpu_addr_i = a;
        wait_gnt();
        @(posedge clk);
        #1;
        cpu_bus.cpu_en_i = 1'b0;
        d = cpu_bus.cpu_rdata_o;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++) wr(6'(i), 32'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        accel_done = 1'b0;
        cpu_bus.cpu_en_i = 1'b0;
        cpu_bus.cpu_we_i = 1'b0;
        cpu_bus.cpu_addr_i = '0;
        cpu_bus.cpu_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", cpu_bus.cpu_rdata_o, 32'd0);
        rst = 1'b1;
        step();
        rd(6'h21, rv);
        check("rst_status", rv, 32'h0000);

        // Plain fill of all 32 words, no job started.
        fill_all();
        rd(6'h21, rv);
        check("fill_status", rv, 32'h2010);
        check("fill_we_cnt", we_cnt, 32);
        check("fill_no_start", start_cnt, 0);
        wr(6'h20, 32'h8);
        rd(6'h21, rv);
        check("abort_idle_status", rv, 32'h0000);

        // Incomplete buffer with a rewrite, then START.
        for (int i = 0; i < 31; i++) wr(6'(i), 32'(i));
        wr(6'd5, 32'd5);
        wr(6'h20, 32'h1);
        rd(6'h21, rv);
        check("incomplete_status", rv, 32'h1F40);
        check("incomplete_no_start", start_cnt, 0);
        check("incomplete_irq", {31'd0, irq}, 32'd0);
        wr(6'd31, 32'd31);
        wr(6'h20, 32'h4);
        rd(6'h21, rv);
        check("full_after_clr", rv, 32'h2010);

        // Full job: START, stalled sample write during RUN, done, capture.
        snap = we_cnt;
        wr(6'h20, 32'h1);
        @(negedge clk);
        check("job_start_pulse", {31'd0, accel_start}, 32'd1);
        step();
        cpu_bus.cpu_en_i   = 1'b1;
        cpu_bus.cpu_we_i   = 1'b1;
        cpu_bus.cpu_addr_i = 6'd3;
        cpu_bus.cpu_data_i = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) accel_done = 1'b1;
            @(negedge clk);
            if (c == 1 || c == 10) begin
                check("run_gnt", {31'd0, cpu_bus.cpu_gnt_o}, 32'd0);
                check("run_buf_en", {31'd0, buf_en}, 32'd0);
            end
            step();
        end
        accel_done = 1'b0;
        @(negedge clk);
        check("capture_mem_en", {31'd0, accel_mem_en}, 32'd1);
        check("capture_gnt", {31'd0, cpu_bus.cpu_gnt_o}, 32'd0);
        check("capture_irq", {31'd0, irq}, 32'd0);
        step();
        @(negedge clk);
        check("idle_gnt", {31'd0, cpu_bus.cpu_gnt_o}, 32'd1);
        check("done_irq", {31'd0, irq}, 32'd1);
        step();
        cpu_bus.cpu_en_i = 1'b0;
        cpu_bus.cpu_we_i = 1'b0;
        check("job_start_cnt", start_cnt, 1);
        check("job_mem_en_cnt", memen_cnt, 1);
        check("held_write_cnt", we_cnt - snap, 1);
        rd(6'h21, rv);
        check("done_status", rv, 32'h0120);
        wr(6'h20, 32'h4);
        @(negedge clk);
        check("irq_clr", {31'd0, irq}, 32'd0);
        step();

        // START with IRQ_CLR while not full: the error flag survives.
        wr(6'h20, 32'h5);
        rd(6'h21, rv);
        check("clr_vs_set", rv, 32'h0140);
        wr(6'h20, 32'hC);
        rd(6'h21, rv);
        check("clr_abort", rv, 32'h0000);

        // Unmapped and non-readable addresses.
        snap = we_cnt;
        wr(6'h30, 32'hDEAD);
        rd(6'h30, rv);
        check("unmapped_rd", rv, 32'd0);
        rd(6'h21, rv);
        rd(6'h20, rv);
        check("ctrl_rd", rv, 32'd0);
        wr(6'd7, 32'd7);
        rd(6'd7, rv);
        check("sample_rd", rv, 32'd0);
        check("unmapped_no_we", we_cnt - snap, 1);
        wr(6'h20, 32'h8);

        // AUTO: the 32nd write launches the job on its own.
        wr(6'h20, 32'h2);
        rd(6'h21, rv);
        check("auto_status", rv, 32'h0004);
        for (int i = 0; i < 31; i++) wr(6'(i), 32'(i));
        check("auto_no_early_start", start_cnt, 1);
        wr(6'd31, 32'd31);
        @(negedge clk);
        check("auto_start", {31'd0, accel_start}, 32'd1);
        step();
        rd(6'h21, rv);
        check("run_status", rv, 32'h2016);

        // ABORT during RUN; a late done is ignored.
        snap = memen_cnt;
        wr(6'h20, 32'h8);
        rd(6'h21, rv);
        check("abort_status", rv, 32'h0000);
        accel_done = 1'b1;
        step();
        accel_done = 1'b0;
        repeat (3) step();
        check("abort_no_mem_en", memen_cnt - snap, 0);
        check("abort_irq", {31'd0, irq}, 32'd0);

        // START and ABORT together: ABORT wins.
        fill_all();
        snap = start_cnt;
        wr(6'h20, 32'h9);
        repeat (3) step();
        check("start_abort_cnt", start_cnt - snap, 0);
        rd(6'h21, rv);
        check("start_abort_status", rv, 32'h0000);

        // Job with no completion from the accelerator.
        fill_all();
        wr(6'h20, 32'h1);
        step();
`ifdef FFT_CTRL_TIMEOUT_EN
        repeat (15) step();
        @(negedge clk);
        check("to_irq_before", {31'd0, irq}, 32'd0);
        step();
        @(negedge clk);
        check("to_irq_after", {31'd0, irq}, 32'd1);
        step();
        rd(6'h21, rv);
        check("to_status", rv, 32'h0080);
        wr(6'h20, 32'h4);
        @(negedge clk);
        check("to_irq_clr", {31'd0, irq}, 32'd0);
        step();
`else
        repeat (40) step();
        rd(6'h21, rv);
        check("no_to_status", rv, 32'h2012);
        check("no_to_irq", {31'd0, irq}, 32'd0);
        wr(6'h20, 32'h8);
        rd(6'h21, rv);
        check("no_to_abort", rv, 32'h0000);
`endif
        check("total_we_cnt", we_cnt, 163);
        check("data_match", we_bad, 0);
        check("total_start_cnt", start_cnt, 3);
        check("total_mem_en_cnt", memen_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
